epp_mem_bridge: RTL

- Synchronous EPP-slave to multi-bank RAM bridge; next generation of the EPP/BRAM communication path.
- Host parallel port gets an 8-bit register map: pointer, bank select, control, auto-incrementing data port and status.
- Drives port A of NBANK 8-bit block RAMs; port B of each RAM stays with fabric logic.
- Adds over the previous path: bank select, address auto-increment, busy stall and strobe synchronisation.

---
 rtl/epp_mem_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/epp_mem_bridge.sv
// epp_mem_bridge
//   Bridges an asynchronous EPP slave interface onto port A of NBANK 8-bit
//   block RAMs. The host sees an 8-bit register map: RAM pointer (lo/hi),
//   bank select, control (auto-increment), an auto-incrementing data port
//   and a read-only status byte. Data-port accesses stall while the fabric
//   owns the RAMs (mem_busy).
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   EppAstb, EppDstb   EPP address/data strobes, active low, asynchronous
//   EppWr              EPP direction, 0 = host write, 1 = host read
//   DB                 EPP data bus, driven only while acknowledging a read
//   EppWait            high = transfer complete
//   ram_addr, ram_din  shared RAM address / write data
//   ram_dout           RAM read data, bank k at bits [8k+7:8k]
//   ram_en             one-cycle RAM enable per access
//   ram_we             one-hot write enable per bank
//   mem_busy           high = fabric owns the RAMs, data-port accesses wait

module epp_mem_bridge #(
    parameter int ADDR_W      = 12,
    parameter int NBANK       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EppAstb,
    input  logic                 EppDstb,
    input  logic                 EppWr,
    inout  wire  [7:0]           DB,
    output logic                 EppWait,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [7:0]           ram_din,
    input  logic [8*NBANK-1:0]   ram_dout,
    output logic                 ram_en,
    output logic [NBANK-1:0]     ram_we,
    input  logic                 mem_busy
);

    typedef enum logic [2:0] {
        IDLE, A_ACC, D_ACC, RAM_WR, RAM_RD, RAM_CAP, ACK
    } state_t;

    localparam logic [7:0] ADDR_DATA = 8'h04;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] astbSync_q, dstbSync_q, wrSync_q;
    logic [7:0]          eppAddr_q, eppAddr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          bank_q, bank_d;
    logic                ctrl_q, ctrl_d;
    logic [7:0]          rdReg_q, rdReg_d;
    logic [7:0]          dbLat_q, dbLat_d;
    logic                isWr_q, isWr_d;
    logic                isAstb_q, isAstb_d;

    logic                astbLow, dstbLow, hostRead;
    logic                bankValid;
    logic [7:0]          regValue;
    logic [7:0]          ramByte;

    // Synchronisers idle high so a reset never looks like a strobe edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            astbSync_q <= '1;
            dstbSync_q <= '1;
            wrSync_q   <= '1;
        end else begin
            astbSync_q <= {astbSync_q[SYNC_STAGES-2:0], EppAstb};
            dstbSync_q <= {dstbSync_q[SYNC_STAGES-2:0], EppDstb};
            wrSync_q   <= {wrSync_q[SYNC_STAGES-2:0], EppWr};
        end
    end

    assign astbLow   = ~astbSync_q[SYNC_STAGES-1];
    assign dstbLow   = ~dstbSync_q[SYNC_STAGES-1];
    assign hostRead  = wrSync_q[SYNC_STAGES-1];
    assign bankValid = (bank_q < 8'(NBANK));

    // Host-visible register read value for the current EPP address.
    always_comb begin
        regValue = 8'h00;
        case (eppAddr_q)
            8'h00:   regValue = ptr_q[7:0];
            8'h01:   regValue = 8'(ptr_q >> 8);
            8'h02:   regValue = bank_q;
            8'h03:   regValue = {7'b0, ctrl_q};
            8'h05:   regValue = {6'b0, ~bankValid, mem_busy};
            default: regValue = 8'h00;
        endcase
    end

    // Bank mux on RAM read data; an out-of-range bank reads as zero.
    always_comb begin
        ramByte = 8'h00;
        for (int k = 0; k < NBANK; k++) begin
            if (bank_q == 8'(k)) begin
                ramByte = ram_dout[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            eppAddr_q <= 8'h00;
            ptr_q     <= '0;
            bank_q    <= 8'h00;
            ctrl_q    <= 1'b1;
            rdReg_q   <= 8'h00;
            dbLat_q   <= 8'h00;
            isWr_q    <= 1'b0;
            isAstb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            eppAddr_q <= eppAddr_d;
            ptr_q     <= ptr_d;
            bank_q    <= bank_d;
            ctrl_q    <= ctrl_d;
            rdReg_q   <= rdReg_d;
            dbLat_q   <= dbLat_d;
            isWr_q    <= isWr_d;
            isAstb_q  <= isAstb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        eppAddr_d = eppAddr_q;
        ptr_d     = ptr_q;
        bank_d    = bank_q;
        ctrl_d    = ctrl_q;
        rdReg_d   = rdReg_q;
        dbLat_d   = dbLat_q;
        isWr_d    = isWr_q;
        isAstb_d  = isAstb_q;
        case (state_q)
            // DB and direction are captured on the first synced strobe
            // cycle; the host holds them stable until we acknowledge.
            IDLE: begin
                if (astbLow) begin
                    state_d  = A_ACC;
                    isAstb_d = 1'b1;
                    isWr_d   = ~hostRead;
                    dbLat_d  = DB;
                end else if (dstbLow) begin
                    state_d  = D_ACC;
                    isAstb_d = 1'b0;
                    isWr_d   = ~hostRead;
                    dbLat_d  = DB;
                end
            end
            A_ACC: begin
                if (isWr_q) eppAddr_d = dbLat_q;
                else        rdReg_d   = eppAddr_q;
                state_d = ACK;
            end
            D_ACC: begin
                if (eppAddr_q == ADDR_DATA) begin
                    if (!mem_busy) state_d = isWr_q ? RAM_WR : RAM_RD;
                end else begin
                    if (isWr_q) begin
                        case (eppAddr_q)
                            8'h00:   ptr_d[7:0] = dbLat_q;
                            8'h01:   ptr_d = ADDR_W'({dbLat_q, ptr_q[7:0]});
                            8'h02:   bank_d = dbLat_q;
                            8'h03:   ctrl_d = dbLat_q[0];
                            default: ;
                        endcase
                    end else begin
                        rdReg_d = regValue;
                    end
                    state_d = ACK;
                end
            end
            RAM_WR: begin
                if (ctrl_q) ptr_d = ptr_q + ADDR_W'(1);
                state_d = ACK;
            end
            RAM_RD: state_d = RAM_CAP;
            RAM_CAP: begin
                rdReg_d = ramByte;
                if (ctrl_q) ptr_d = ptr_q + ADDR_W'(1);
                state_d = ACK;
            end
            ACK: begin
                if (isAstb_q ? ~astbLow : ~dstbLow) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port A outputs depend only on registered state.
    always_comb begin
        EppWait  = (state_q == ACK);
        ram_addr = ptr_q;
        ram_din  = dbLat_q;
        ram_en   = (state_q == RAM_WR) || (state_q == RAM_RD);
        ram_we   = '0;
        if (state_q == RAM_WR) begin
            for (int k = 0; k < NBANK; k++) begin
                if (bank_q == 8'(k)) ram_we[k] = 1'b1;
            end
        end
    end

    assign DB = (state_q == ACK && !isWr_q) ? rdReg_q : 8'hzz;

endmodule
